// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART frame constants, state encodings and parity helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 234;
    localparam int UART_GUARD_CLKS_DEFAULT   = 234;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;
    localparam uart_state_t ST_GUARD  = 3'd5;

    // Even parity; the receiver calls the same function so both ends agree.
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fpga_if.sv
// ============================================================================
// Module : uart_tx_fpga_if
// Brief  : Host-side byte handshake into the UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_fpga_if;
    import uart_pkg::*;

    logic                      i_txStart;
    logic [UART_DATA_BITS-1:0] i_txByte;
    logic                      o_txReady;

    modport master (output i_txStart, output i_txByte, input  o_txReady);
    modport slave  (input  i_txStart, input  i_txByte, output o_txReady);
endinterface

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module : uart_bit_timer
// Brief  : Wrapping interval counter with terminal-count pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_bit_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_load,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_termCount,
    output logic                  o_tick
);

    logic [WIDTH-1:0] r_count;

    assign o_tick = i_en && (r_count == i_termCount);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tick ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fpga.sv
// ============================================================================
// Module : uart_tx_fpga
// Brief  : 8E1 UART transmitter with one-deep holding register and idle guard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fpga
    import uart_pkg::*;
#(
    parameter int clksPerBit = UART_CLKS_PER_BIT_DEFAULT,
    parameter int guardClks  = UART_GUARD_CLKS_DEFAULT
) (
    input  wire logic     i_clkTx,
    input  wire logic     i_rstTx_n,
    uart_tx_fpga_if.slave txIf,
    output logic          o_txBit,
    output logic          o_txBusy,
    output logic          o_txDone
);

    localparam int c_cntMax = (clksPerBit > guardClks) ? clksPerBit : guardClks;
    localparam int c_cntW   = (c_cntMax > 1) ? $clog2(c_cntMax) : 1;
    localparam logic [c_cntW-1:0] c_bitTerm   = c_cntW'(clksPerBit - 1);
    localparam logic [c_cntW-1:0] c_guardTerm = c_cntW'((guardClks > 0) ? guardClks - 1 : 0);
    localparam logic [2:0]        c_lastBit   = 3'(UART_DATA_BITS - 1);

    uart_state_t               r_state, w_stateNext;
    logic                      r_holdValid;
    logic [UART_DATA_BITS-1:0] r_holdByte;
    logic [UART_DATA_BITS:0]   r_shift;
    logic [2:0]                r_bitIdx, w_bitIdxNext;
    logic                      r_txBit, w_txBitNext;
    logic                      r_txDone, w_txDoneNext;
    logic                      w_tick, w_accept, w_consume;
    logic [c_cntW-1:0]         w_term;

    assign w_accept  = txIf.i_txStart && !r_holdValid;
    assign w_consume = (r_state == ST_IDLE) && r_holdValid;
    assign w_term    = (r_state == ST_GUARD) ? c_guardTerm : c_bitTerm;

    // One timer serves both the bit period and the guard interval; it wraps
    // on every tick so each new state starts counting from zero.
    uart_bit_timer #(.WIDTH(c_cntW)) u_timer (
        .i_clk       (i_clkTx),
        .i_rst_n     (i_rstTx_n),
        .i_load      (r_state == ST_IDLE),
        .i_en        (r_state != ST_IDLE),
        .i_termCount (w_term),
        .o_tick      (w_tick)
    );

    always_ff @(posedge i_clkTx) begin
        if (!i_rstTx_n) r_state <= ST_IDLE;
        else            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:   if (r_holdValid) w_stateNext = ST_START;
            ST_START:  if (w_tick) w_stateNext = ST_DATA;
            ST_DATA:   if (w_tick && r_bitIdx == c_lastBit) w_stateNext = ST_PARITY;
            ST_PARITY: if (w_tick) w_stateNext = ST_STOP;
            ST_STOP:   if (w_tick) w_stateNext = (guardClks == 0) ? ST_IDLE : ST_GUARD;
            ST_GUARD:  if (w_tick) w_stateNext = ST_IDLE;
            default:   w_stateNext = ST_IDLE;
        endcase
    end

    // Line value is derived from the next state so o_txBit can be registered
    // without adding a cycle of latency to the frame.
    always_comb begin
        w_bitIdxNext = r_bitIdx;
        w_txBitNext  = 1'b1;
        w_txDoneNext = (r_state == ST_STOP) && w_tick;
        if (r_state == ST_START)
            w_bitIdxNext = 3'd0;
        else if (r_state == ST_DATA && w_tick)
            w_bitIdxNext = r_bitIdx + 3'd1;
        case (w_stateNext)
            ST_START:  w_txBitNext = 1'b0;
            ST_DATA:   w_txBitNext = r_shift[w_bitIdxNext];
            ST_PARITY: w_txBitNext = r_shift[UART_DATA_BITS];
            default:   w_txBitNext = 1'b1;
        endcase
    end

    always_ff @(posedge i_clkTx) begin
        if (!i_rstTx_n) begin
            r_holdValid <= 1'b0;
            r_holdByte  <= '0;
            r_shift     <= '0;
            r_bitIdx    <= 3'd0;
            r_txBit     <= 1'b1;
            r_txDone    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_holdValid <= 1'b1;
                r_holdByte  <= txIf.i_txByte;
            end
            if (w_consume) begin
                r_holdValid <= 1'b0;
                r_shift     <= {uart_parity(r_holdByte), r_holdByte};
            end
            r_bitIdx <= w_bitIdxNext;
            r_txBit  <= w_txBitNext;
            r_txDone <= w_txDoneNext;
        end
    end

    assign txIf.o_txReady = !r_holdValid;
    assign o_txBit        = r_txBit;
    assign o_txBusy       = (r_state != ST_IDLE);
    assign o_txDone       = r_txDone;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fpga.sv
// ============================================================================
// Module : tb_uart_tx_fpga
// Brief  : Directed self-checking bench for uart_tx_fpga (4 clks/bit, guard 3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fpga;

    localparam int CPB   = 4;
    localparam int GUARD = 3;
    localparam int FRAME = 11 * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic o_txBit, o_txBusy, o_txDone;
    int   nChk = 0;
    int   nErr = 0;
    int   cyc  = 0;

    uart_tx_fpga_if busIf ();

    uart_tx_fpga #(.clksPerBit(CPB), .guardClks(GUARD)) dut (
        .i_clkTx   (clk),
        .i_rstTx_n (rst_n),
        .txIf      (busIf),
        .o_txBit   (o_txBit),
        .o_txBusy  (o_txBusy),
        .o_txDone  (o_txDone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        while (busIf.o_txReady !== 1'b1 && n < 300) begin step(); n++; end
        check("sendReadyWait", busIf.o_txReady, 1);
        busIf.i_txStart = 1'b1;
        busIf.i_txByte  = b;
        step();
        busIf.i_txStart = 1'b0;
        check("readyLowAfterAccept", busIf.o_txReady, 0);
    endtask

    // Samples one frame starting at the falling start edge; returns positioned
    // on the cycle after the post-guard IDLE cycle.
    task automatic captureFrame(output logic [10:0] bits, output int doneAt,
                                output int doneCnt, output int glitches,
                                output int busyBad, output int startCyc);
        logic line [FRAME];
        int   n = 0;
        bits = '1; doneAt = -1; doneCnt = 0; glitches = 0; busyBad = 0; startCyc = -1;
        while (o_txBit !== 1'b0 && n < 300) begin step(); n++; end
        if (o_txBit !== 1'b0) begin
            check("startEdgeTimeout", o_txBit, 0);
            return;
        end
        startCyc = cyc;
        for (int c = 0; c < FRAME + GUARD + 1; c++) begin
            if (c < FRAME) line[c] = o_txBit;
            if (o_txDone) begin doneCnt++; doneAt = c; end
            if (c < FRAME + GUARD && o_txBusy !== 1'b1) busyBad++;
            if (c == FRAME + GUARD && o_txBusy !== 1'b0) busyBad++;
            step();
        end
        for (int c = 0; c < FRAME; c++) begin
            if (c % CPB == 1) bits[c / CPB] = line[c];
        end
        for (int c = 0; c < FRAME; c++) begin
            if (line[c] !== bits[c / CPB]) glitches++;
        end
    endtask

    task automatic checkFrame(input string tag, input logic [10:0] exp, input logic [10:0] bits,
                              input int doneAt, input int doneCnt, input int glitches,
                              input int busyBad);
        check({tag, ".bits"},    32'(bits), 32'(exp));
        check({tag, ".doneAt"},  doneAt, FRAME);
        check({tag, ".doneCnt"}, doneCnt, 1);
        check({tag, ".hold"},    glitches, 0);
        check({tag, ".busy"},    busyBad, 0);
    endtask

    initial begin
        logic [10:0] bits;
        int doneAt, doneCnt, glitches, busyBad, s1, s2, bad;

        busIf.i_txStart = 1'b0;
        busIf.i_txByte  = 8'h00;
        repeat (3) step();
        check("rst.txBit", o_txBit, 1);
        check("rst.ready", busIf.o_txReady, 1);
        check("rst.busy",  o_txBusy, 0);
        check("rst.done",  o_txDone, 0);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (o_txBit !== 1'b1 || busIf.o_txReady !== 1'b1 || o_txBusy !== 1'b0) bad++;
        end
        check("idle100", bad, 0);

        // 0xA5: four ones -> parity 0
        sendByte(8'hA5);
        captureFrame(bits, doneAt, doneCnt, glitches, busyBad, s1);
        checkFrame("fA5", {1'b1, 1'b0, 8'hA5, 1'b0}, bits, doneAt, doneCnt, glitches, busyBad);

        // 0x07: three ones -> parity 1; decode as the receiver would
        sendByte(8'h07);
        captureFrame(bits, doneAt, doneCnt, glitches, busyBad, s1);
        checkFrame("f07", {1'b1, 1'b1, 8'h07, 1'b0}, bits, doneAt, doneCnt, glitches, busyBad);
        check("rx07.data",     bits[8:1], 8'h07);
        check("rx07.parErr",   ^bits[9:1], 0);

        // 0x3C with 0x55 queued mid-frame and a dropped 0xFF
        sendByte(8'h3C);
        fork
            captureFrame(bits, doneAt, doneCnt, glitches, busyBad, s1);
            begin
                repeat (14) step();
                sendByte(8'h55);
                busIf.i_txStart = 1'b1;
                busIf.i_txByte  = 8'hFF;
                step();
                busIf.i_txStart = 1'b0;
                repeat (32) step();
                check("holdUntilConsume", busIf.o_txReady, 0);
            end
        join
        checkFrame("f3C", {1'b1, 1'b0, 8'h3C, 1'b0}, bits, doneAt, doneCnt, glitches, busyBad);
        check("readyAfterConsume", busIf.o_txReady, 1);
        captureFrame(bits, doneAt, doneCnt, glitches, busyBad, s2);
        checkFrame("f55", {1'b1, 1'b0, 8'h55, 1'b0}, bits, doneAt, doneCnt, glitches, busyBad);
        check("b2bSpacing", s2 - s1, FRAME + GUARD + 1);

        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (o_txBit !== 1'b1 || o_txBusy !== 1'b0) bad++;
            step();
        end
        check("droppedFF", bad, 0);

        // Reset in the middle of DATA (line low at that point for 0xF0)
        sendByte(8'hF0);
        repeat (10) step();
        check("preRst.txBit", o_txBit, 0);
        rst_n = 1'b0;
        step();
        check("midRst.txBit", o_txBit, 1);
        check("midRst.ready", busIf.o_txReady, 1);
        check("midRst.busy",  o_txBusy, 0);
        check("midRst.done",  o_txDone, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (o_txBit !== 1'b1 || o_txDone !== 1'b0) bad++;
        end
        check("noTruncDone", bad, 0);

        sendByte(8'h81);
        captureFrame(bits, doneAt, doneCnt, glitches, busyBad, s1);
        checkFrame("f81", {1'b1, 1'b0, 8'h81, 1'b0}, bits, doneAt, doneCnt, glitches, busyBad);

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fpga.md
# uart_tx_fpga

- UART transmitter matching the team's 8-bit receiver frame format: start bit (0), 8 data bits LSB first, even-parity bit (`^data`), one stop bit (1).
- Each bit is held for `clksPerBit` clocks.
- A one-deep holding register with a ready/start handshake lets the host queue the next byte while a frame is on the line.
- A programmable idle guard after each stop bit gives the receiver time to return to idle before the next start edge.

## Interface
- `clksPerBit`, default 234: clocks per bit; legal range ≥ 2.
- `guardClks`, default 234: clocks of forced idle-high after each stop bit; 0 means no guard.
- `i_clkTx` in 1: transmitter clock.
- `i_rstTx_n` in 1: reset, synchronous, active-low.
- `i_txStart` in 1: host requests transmission of `i_txByte`; accepted only while `o_txReady`=1.
- `i_txByte` in 8: byte to send, sampled on acceptance.
- `o_txBit` out 1: serial line, registered; idle high.
- `o_txReady` out 1: holding register empty.
- `o_txBusy` out 1: FSM not in IDLE.
- `o_txDone` out 1: one-cycle pulse when the stop bit completes.

## Operation
- **Handshake:** the byte is accepted on any edge where `i_txStart`=1 and `o_txReady`=1. The holding register captures `i_txByte` and `o_txReady`=0 from the next cycle. `i_txStart` while `o_txReady`=0 is ignored; the byte is dropped silently.
- **`o_txReady`** = NOT holdValid. The FSM consumes the holding register only in IDLE, when ready is already 0, so accept and consume never coincide.
- **Shift register:** on consume, load shift reg = {parity, data} with parity = `^data`, clear holdValid, and go to START.
- **IDLE:** `o_txBit`=1. If holdValid, load the shift register and go to START.
- **START:** `o_txBit`=0 for `clksPerBit` clocks, then go to DATA with bitIndex=0.
- **DATA:** `o_txBit`=data[bitIndex] for `clksPerBit` clocks each. After bitIndex 7, go to PARITY.
- **PARITY:** `o_txBit`=parity for `clksPerBit` clocks, then go to STOP.
- **STOP:** `o_txBit`=1 for `clksPerBit` clocks. On the last clock, pulse `o_txDone`, then go to GUARD, or to IDLE if `guardClks`=0.
- **GUARD:** `o_txBit`=1 for `guardClks` clocks, then go to IDLE.
- **Bit counter:** counts 0..`clksPerBit`-1 and wraps to 0 on each bit boundary. Its width is `$clog2(max(clksPerBit, guardClks))`. There is no overflow for legal parameters.
- **Reset** (any state, mid-frame included) gives on the next edge:
  - FSM=IDLE, holdValid=0, counters 0.
  - `o_txBit`=1, `o_txReady`=1, `o_txBusy`=0, `o_txDone`=0.
  - A truncated frame is not completed and produces no done pulse.
- Illegal state encodings recover to IDLE with `o_txBit`=1.

## Timing
- Acceptance at edge N: holdValid=1 after N. At edge N+1, IDLE→START, `o_txBit`=0 visible after N+1.
- Each of the 11 bits lasts exactly `clksPerBit` cycles, so the frame is 11·`clksPerBit` cycles from start falling edge to stop end.
- `o_txDone` is high for the single cycle following the last STOP edge, aligned with the GUARD/IDLE entry.
- **`o_txBusy`:** 1 from START entry through the end of GUARD.
- **`o_txReady`:** returns to 1 the cycle after IDLE consumes, so the next byte can be queued during the frame.
- **Back-to-back:** with the holding register refilled, start edges are spaced 11·`clksPerBit` + `guardClks` + 1 cycles apart (one IDLE cycle).

## Structure
- **Package `uart_pkg`:**
  - State encodings: IDLE, START, DATA, PARITY, STOP, GUARD (3 bits).
  - `UART_DATA_BITS`=8.
  - Default `clksPerBit`.
  - Function `uart_parity(byte)` returning `^byte`, shared with the receiver so both ends agree.
- **Sub-module `uart_bit_timer`:** load/count/terminal-count pulse, parameterised by width. It is reused for the bit period and the guard interval.

## Test plan
- Reset, then idle 100 cycles → `o_txBit`=1, `o_txReady`=1, `o_txBusy`=0 throughout.
- `clksPerBit`=4, send 0xA5 → line 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles. `o_txDone` pulses once at cycle 44 after the start edge.
- Send 0x07 → parity bit 1. Loop the frame into the receiver → same byte, `o_parityError`=0.
- Queue 0x55 during 0x3C's DATA phase → `o_txReady`=0 until the IDLE consume. Next start edge at 11·4 + `guardClks` + 1 cycles after the first.
- Pulse `i_txStart` with 0xFF while `o_txReady`=0 → byte dropped; only the queued frames appear.
- Assert `i_rstTx_n`=0 mid-DATA → `o_txBit`=1 the next cycle, no `o_txDone`, `o_txReady`=1. A subsequent 0x81 transmits a correct full frame.
